// File: rtl/vtg_pkg.sv
// Shared video timing types, presets and helpers.
// Used by vtg_prog and vtg_axis.
package vtg_pkg;

   localparam int VTG_CW = 12;

   typedef logic [VTG_CW-1:0] vtg_cnt_t;
   typedef logic [VTG_CW+1:0] vtg_tot_t;

   typedef struct packed {
      vtg_cnt_t h_active;
      vtg_cnt_t h_fp;
      vtg_cnt_t h_sync;
      vtg_cnt_t h_bp;
      vtg_cnt_t v_active;
      vtg_cnt_t v_fp;
      vtg_cnt_t v_sync;
      vtg_cnt_t v_bp;
      logic     hsync_pol;
      logic     vsync_pol;
   } vtg_timing_t;

   localparam vtg_tot_t TOT_ONE = vtg_tot_t'(1);
   localparam vtg_tot_t TOT_MAX = vtg_tot_t'((1 << VTG_CW) - 1);

   localparam vtg_timing_t TIMING_720P60 = '{
      h_active : vtg_cnt_t'(1280),
      h_fp     : vtg_cnt_t'(110),
      h_sync   : vtg_cnt_t'(40),
      h_bp     : vtg_cnt_t'(220),
      v_active : vtg_cnt_t'(720),
      v_fp     : vtg_cnt_t'(5),
      v_sync   : vtg_cnt_t'(5),
      v_bp     : vtg_cnt_t'(20),
      hsync_pol: 1'b1,
      vsync_pol: 1'b1
   };

   localparam vtg_timing_t TIMING_1080P30 = '{
      h_active : vtg_cnt_t'(1920),
      h_fp     : vtg_cnt_t'(88),
      h_sync   : vtg_cnt_t'(44),
      h_bp     : vtg_cnt_t'(148),
      v_active : vtg_cnt_t'(1080),
      v_fp     : vtg_cnt_t'(4),
      v_sync   : vtg_cnt_t'(5),
      v_bp     : vtg_cnt_t'(36),
      hsync_pol: 1'b1,
      vsync_pol: 1'b1
   };

   // Sum computed two bits wider so oversize configs are detectable.
   function automatic vtg_tot_t vtg_total(
      input vtg_cnt_t a,
      input vtg_cnt_t f,
      input vtg_cnt_t s,
      input vtg_cnt_t b
   );
      return vtg_tot_t'(a) + vtg_tot_t'(f) + vtg_tot_t'(s) + vtg_tot_t'(b);
   endfunction

endpackage

// File: rtl/vtg_axis.sv
// One timing axis: position counter, wrap, active and sync decode.
// Ports: clk/rst_n, step (advance), load (register pos/sync), timing
// fields + pol in; act/first/last (comb, on next position), pos, sync out.
module vtg_axis #(
   parameter int   CW      = 12,
   parameter logic RST_POL = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          step,
   input  logic          load,
   input  logic [CW-1:0] t_active,
   input  logic [CW-1:0] t_fp,
   input  logic [CW-1:0] t_sync,
   input  logic [CW-1:0] t_bp,
   input  logic          pol,
   output logic          act,
   output logic          first,
   output logic          last,
   output logic [CW-1:0] pos,
   output logic          sync
);

   localparam logic [CW-1:0] C_ONE = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW+1:0] T_ONE = {{(CW+1){1'b0}}, 1'b1};

   // cnt is the position that the next load presents on pos.
   logic [CW-1:0] cnt;
   logic [CW+1:0] cnt_x;
   logic [CW+1:0] sync_lo;
   logic [CW+1:0] sync_hi;
   logic [CW+1:0] tot;
   logic          swin;

   assign cnt_x   = {2'b00, cnt};
   assign sync_lo = {2'b00, t_active} + {2'b00, t_fp};
   assign sync_hi = sync_lo + {2'b00, t_sync};
   assign tot     = sync_hi + {2'b00, t_bp};

   assign act   = cnt < t_active;
   assign first = cnt == '0;
   assign last  = cnt_x == tot - T_ONE;
   assign swin  = (cnt_x >= sync_lo) && (cnt_x < sync_hi);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt  <= '0;
         pos  <= '0;
         sync <= ~RST_POL;
      end else begin
         if (step) begin
            cnt <= last ? '0 : cnt + C_ONE;
         end
         if (load) begin
            pos  <= cnt;
            sync <= swin ? pol : ~pol;
         end
      end
   end

endmodule

// File: rtl/vtg_prog.sv
// Programmable video timing generator with frame-synchronous reconfig.
// Ports: clk_hdmi, rst_hdmi_n, ce; cfg_timing/cfg_load in, cfg_pending/
// cfg_err out; hcount, vcount, de, hsync, vsync, line_start, frame_start.
module vtg_prog
   import vtg_pkg::*;
#(
   parameter int          CW         = VTG_CW,
   parameter vtg_timing_t RST_TIMING = TIMING_720P60
) (
   input  logic          clk_hdmi,
   input  logic          rst_hdmi_n,
   input  logic          ce,
   input  vtg_timing_t   cfg_timing,
   input  logic          cfg_load,
   output logic          cfg_pending,
   output logic          cfg_err,
   output logic [CW-1:0] hcount,
   output logic [CW-1:0] vcount,
   output logic          de,
   output logic          hsync,
   output logic          vsync,
   output logic          line_start,
   output logic          frame_start
);

   vtg_timing_t act_t;
   vtg_timing_t shd_t;
   vtg_timing_t eff_t;
   vtg_tot_t    h_tot;
   vtg_tot_t    v_tot;
   vtg_tot_t    c_htot;
   vtg_tot_t    c_vtot;
   logic        at_end;
   logic        apply;
   logic        cfg_ok;
   logic        h_act;
   logic        h_first;
   logic        h_last;
   logic        v_act;
   logic        v_first;
   logic        v_last_unused;

   assign h_tot = vtg_total(act_t.h_active, act_t.h_fp,
                            act_t.h_sync, act_t.h_bp);
   assign v_tot = vtg_total(act_t.v_active, act_t.v_fp,
                            act_t.v_sync, act_t.v_bp);

   assign c_htot = vtg_total(cfg_timing.h_active, cfg_timing.h_fp,
                             cfg_timing.h_sync, cfg_timing.h_bp);
   assign c_vtot = vtg_total(cfg_timing.v_active, cfg_timing.v_fp,
                             cfg_timing.v_sync, cfg_timing.v_bp);

   assign cfg_ok = (cfg_timing.h_active != '0) &&
                   (cfg_timing.h_sync   != '0) &&
                   (cfg_timing.v_active != '0) &&
                   (cfg_timing.v_sync   != '0) &&
                   (c_htot <= TOT_MAX) &&
                   (c_vtot <= TOT_MAX);

   // Presented position is the last of the frame: this edge presents
   // (0,0) of the next frame, so it is decoded with the shadow timing.
   assign at_end = (vtg_tot_t'(hcount) == h_tot - TOT_ONE) &&
                   (vtg_tot_t'(vcount) == v_tot - TOT_ONE);
   assign apply  = ce && at_end;
   assign eff_t  = apply ? shd_t : act_t;

   vtg_axis #(
      .CW      (CW),
      .RST_POL (RST_TIMING.hsync_pol)
   ) u_h (
      .clk      (clk_hdmi),
      .rst_n    (rst_hdmi_n),
      .step     (ce),
      .load     (ce),
      .t_active (eff_t.h_active),
      .t_fp     (eff_t.h_fp),
      .t_sync   (eff_t.h_sync),
      .t_bp     (eff_t.h_bp),
      .pol      (eff_t.hsync_pol),
      .act      (h_act),
      .first    (h_first),
      .last     (h_last),
      .pos      (hcount),
      .sync     (hsync)
   );

   // Vertical outputs only reload at the start of a line.
   vtg_axis #(
      .CW      (CW),
      .RST_POL (RST_TIMING.vsync_pol)
   ) u_v (
      .clk      (clk_hdmi),
      .rst_n    (rst_hdmi_n),
      .step     (ce && h_last),
      .load     (ce && h_first),
      .t_active (eff_t.v_active),
      .t_fp     (eff_t.v_fp),
      .t_sync   (eff_t.v_sync),
      .t_bp     (eff_t.v_bp),
      .pol      (eff_t.vsync_pol),
      .act      (v_act),
      .first    (v_first),
      .last     (v_last_unused),
      .pos      (vcount),
      .sync     (vsync)
   );

   always_ff @(posedge clk_hdmi) begin
      if (!rst_hdmi_n) begin
         act_t       <= RST_TIMING;
         shd_t       <= RST_TIMING;
         cfg_pending <= 1'b0;
         cfg_err     <= 1'b0;
         de          <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         cfg_err <= cfg_load && !cfg_ok;
         if (apply) begin
            act_t <= shd_t;
         end
         // A load on the apply edge wins: it refills the shadow.
         if (cfg_load && cfg_ok) begin
            shd_t       <= cfg_timing;
            cfg_pending <= 1'b1;
         end else if (apply) begin
            cfg_pending <= 1'b0;
         end
         if (ce) begin
            de          <= h_act && v_act;
            line_start  <= h_first;
            frame_start <= h_first && v_first;
         end
      end
   end

endmodule

// File: doc/vtg_prog.md
VTG_PROG -- requirements
Module: vtg_prog

Interface
REQ-001 SHALL have parameter CW, default 12: width of counters and timing fields.
REQ-002 SHALL have parameter RST_TIMING (vtg_timing_t), default TIMING_720P60: active timing after reset.
REQ-003 SHALL have port clk_hdmi, input, 1: pixel clock; one clock; all logic on its rising edge.
REQ-004 SHALL have port rst_hdmi_n, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port ce, input, 1: pixel advance enable; when low, all state and outputs hold.
REQ-006 SHALL have port cfg_timing, input, vtg_timing_t: new timing, i.e. {h,v}_{active,fp,sync,bp} at CW bits each, plus hsync_pol and vsync_pol.
REQ-007 SHALL have port cfg_load, input, 1: single-cycle strobe that captures cfg_timing.
REQ-008 SHALL have port cfg_pending, output, 1: a validated config is waiting for the frame boundary.
REQ-009 SHALL have port cfg_err, output, 1: one-cycle pulse when a rejected cfg_load occurs.
REQ-010 SHALL have ports hcount and vcount, output, CW each: current pixel position.
REQ-011 SHALL have ports de, hsync and vsync, output, 1 each: video timing, with sync outputs at programmed polarity.
REQ-012 SHALL have ports line_start and frame_start, output, 1 each: pulse at hcount==0, and at hcount==0 && vcount==0.

Function
REQ-013 SHALL define totals as h_total = h_active+h_fp+h_sync+h_bp and v_total likewise, computed CW+2 bits wide.
REQ-014 SHALL order each line as active [0, h_active), then front porch, then sync, then back porch; the vertical axis SHALL use the same order.
REQ-015 SHALL advance hcount by 1 per ce cycle, wrap from h_total-1 to 0, and advance vcount on each wrap.
REQ-016 SHALL wrap vcount from v_total-1 to 0.
REQ-017 SHALL register all outputs, each describing the same position as hcount/vcount in the same cycle.
REQ-018 SHALL assert de iff hcount<h_active && vcount<v_active.
REQ-019 SHALL drive hsync at hsync_pol iff h_active+h_fp <= hcount < h_active+h_fp+h_sync, and at !hsync_pol otherwise.
REQ-020 SHALL drive vsync at vsync_pol iff the vertical sync window per REQ-019 holds on vcount; vsync changes only on cycles where hcount==0.
REQ-021 SHALL reject a cfg_load if h_active, h_sync, v_active or v_sync is 0, or if h_total or v_total > 2^CW-1; a rejected load pulses cfg_err the next cycle and leaves the shadow and cfg_pending unchanged.
REQ-022 SHALL, on a valid cfg_load, capture cfg_timing into the shadow and set cfg_pending, regardless of ce.
REQ-023 SHALL copy the shadow into the active timing on the ce cycle where hcount==h_total-1 && vcount==v_total-1, and clear cfg_pending then, so the following frame_start uses the new timing.
REQ-024 SHALL, when a valid cfg_load coincides with the REQ-023 apply cycle, apply the old shadow, capture the new one into the shadow, and keep cfg_pending=1.
REQ-025 SHALL let a later valid cfg_load before apply overwrite the shadow (last write wins).
REQ-026 SHALL evaluate position only against the active timing, never the shadow, mid-frame.

Reset
REQ-027 SHALL, while rst_hdmi_n=0, set: internal counters=0, active and shadow timing=RST_TIMING, cfg_pending=0, cfg_err=0, hcount=vcount=0, de=0, line_start=frame_start=0, hsync=!RST_TIMING.hsync_pol, vsync=!RST_TIMING.vsync_pol.
REQ-028 SHALL, on the first ce edge after release, present position (0,0) with de=1, line_start=1, frame_start=1.
REQ-029 SHALL, on reset mid-frame, discard any pending config and restart at (0,0) per REQ-028.

Structure
REQ-030 SHALL place vtg_timing_t and the preset constants TIMING_720P60 and TIMING_1080P30 in shared package vtg_pkg; CW-dependent widths SHALL be parameterised there.
REQ-031 SHALL use one sub-module vtg_axis (counter, wrap, active and sync window decode), instantiated once for horizontal and once for vertical, the vertical instance advancing on the horizontal wrap.

Verification
REQ-032 SHALL check: timing h=8/2/2/2 and v=4/1/1/1 with ce=1 -> h_total=14, v_total=7; de high for 32 cycles per 98-cycle frame; hsync active at hcount 10-11; vsync active for vcount=5 (14 cycles, starting at hcount=0).
REQ-033 SHALL check: cfg_load of h_active=6 mid-frame -> cfg_pending=1 until the frame end at (13,6); the next line has h_total=12 and cfg_pending=0.
REQ-034 SHALL check: cfg_load with h_sync=0, then with h_total=4096 at CW=12 -> cfg_err pulses once each; timing and cfg_pending are unchanged.
REQ-035 SHALL check: a cfg_load on the apply cycle -> the earlier shadow is applied and the new one applied one frame later; cfg_pending stays 1 across the boundary.
REQ-036 SHALL check: ce toggling 1/0 -> each position is held exactly 2 cycles and frame length doubles to 196 cycles.
REQ-037 SHALL check: reset asserted at (5,2) with a pending config -> outputs take reset values; after release, frame_start occurs on the first edge with RST_TIMING and cfg_pending=0.
